// File: rtl/bus_pkg.sv
// Shared bus constants and arbiter state encoding, used by the arbiter and the bus encoder.
package bus_pkg;

    localparam int unsigned NUM_BUS_SRC = 24;
    localparam int unsigned BUS_SEL_W   = 32;
    localparam int unsigned BUS_ID_W    = 5;

    // Holder index reported when nobody drives the bus.
    localparam logic [BUS_ID_W-1:0] BUS_ID_NONE = 5'd31;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StHold  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_request_arbiter_if.sv
// Request/grant bundle between control logic, the arbiter and the bus encoder.
// master: arbiter side (drives the grant). slave: requester/encoder side.
interface bus_request_arbiter_if
    import bus_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_BUS_SRC
) ();

    logic [NUM_SRC-1:0]   req;
    logic                 lock;
    logic [BUS_SEL_W-1:0] grant;
    logic                 grant_en;
    logic [BUS_ID_W-1:0]  grant_id;
    logic                 busy;

    modport master (
        input  req,
        input  lock,
        output grant,
        output grant_en,
        output grant_id,
        output busy
    );

    modport slave (
        output req,
        output lock,
        input  grant,
        input  grant_en,
        input  grant_id,
        input  busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick
    import bus_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_BUS_SRC
) (
    input  logic [NUM_SRC-1:0]  req_i,
    input  logic [BUS_ID_W-1:0] ptr_i,
    output logic [NUM_SRC-1:0]  win_oh_o,
    output logic [BUS_ID_W-1:0] win_id_o,
    output logic                any_o
);

    localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Scan NUM_SRC positions starting at ptr; the first hit wins.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        win_oh_o = '0;
        win_id_o = BUS_ID_NONE;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = (32'(ptr_i) + i) % NUM_SRC;
            if (!found && req_i[IdxW'(idx)]) begin
                found                 = 1'b1;
                win_oh_o[IdxW'(idx)]  = 1'b1;
                win_id_o              = BUS_ID_W'(idx);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/bus_request_arbiter.sv
// Round-robin bus arbiter with bounded lock-based hold; feeds the bus encoder a registered
// one-hot select. Define BUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module bus_request_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NUM_SRC  = NUM_BUS_SRC,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic                   clk,
    input logic                   clr_n,
    bus_request_arbiter_if.master bus
);

    localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    arb_state_e           state_q, state_d;
    logic [BUS_SEL_W-1:0] grant_q, grant_d;
    logic                 grant_en_q, grant_en_d;
    logic [BUS_ID_W-1:0]  grant_id_q, grant_id_d;
    logic                 busy_q, busy_d;
    logic [3:0]           hold_cnt_q, hold_cnt_d;
    logic                 new_grant;

    logic [NUM_SRC-1:0]   win_oh;
    logic [BUS_ID_W-1:0]  win_id;
    logic                 win_any;
    logic [BUS_ID_W-1:0]  pick_ptr;

`ifdef BUS_ARB_FIXED_PRIO_EN
    // Search always starts at 0, so the lowest requesting index wins.
    assign pick_ptr = '0;
`else
    logic [BUS_ID_W-1:0] ptr_q, ptr_d;

    assign pick_ptr = ptr_q;

    // Pointer moves just past each newly granted source.
    always_comb begin
        ptr_d = ptr_q;
        if (new_grant) begin
            ptr_d = (win_id == BUS_ID_W'(NUM_SRC - 1)) ? '0 : win_id + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .req_i    (bus.req),
        .ptr_i    (pick_ptr),
        .win_oh_o (win_oh),
        .win_id_o (win_id),
        .any_o    (win_any)
    );

    // Next state: extend a locked grant while under the hold limit, else re-arbitrate or idle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_en_d = grant_en_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        hold_cnt_d = hold_cnt_q;
        new_grant  = 1'b0;

        unique case (state_q)
            StIdle: begin
                new_grant = win_any;
            end
            StGrant, StHold: begin
                if (bus.lock && bus.req[IdxW'(grant_id_q)] &&
                    (hold_cnt_q < 4'(MAX_HOLD))) begin
                    state_d    = StHold;
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end else if (win_any) begin
                    new_grant = 1'b1;
                end else begin
                    state_d    = StIdle;
                    grant_d    = '0;
                    grant_en_d = 1'b0;
                    grant_id_d = BUS_ID_NONE;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = StIdle;
                grant_d    = '0;
                grant_en_d = 1'b0;
                grant_id_d = BUS_ID_NONE;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase

        if (new_grant) begin
            state_d    = StGrant;
            grant_d    = BUS_SEL_W'(win_oh);
            grant_en_d = 1'b1;
            grant_id_d = win_id;
            busy_d     = 1'b1;
            hold_cnt_d = 4'd1;
        end
    end

    // State and registered outputs; reset drops the grant without waiting for a clock.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_en_q <= 1'b0;
            grant_id_q <= BUS_ID_NONE;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_en_q <= grant_en_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_en = grant_en_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Bench for bus_request_arbiter: directed scenarios with literal expectations plus a long
// random run, all checked every cycle against a queue-free behavioural model of the rules.
module tb_bus_request_arbiter;
    import bus_pkg::*;

    localparam int N    = 24;
    localparam int MAXH = 4;

    logic clk = 1'b0;
    logic clr_n;

    bus_request_arbiter_if #(.NUM_SRC(N)) bus ();

    bus_request_arbiter #(
        .NUM_SRC  (N),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: holder index (-1 = none), cycles held, search start.
    int m_holder = -1;
    int m_cnt    = 0;
    int m_ptr    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] g, input logic [31:0] id);
        check({name, ".grant"}, bus.grant, g);
        check({name, ".grant_id"}, 32'(bus.grant_id), id);
        check({name, ".grant_en"}, 32'(bus.grant_en), 32'(g != 0));
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Reference model of the arbitration rules.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_holder = -1;
            m_cnt    = 0;
            m_ptr    = 0;
        end else begin
            int w;
            int start;
`ifdef BUS_ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = m_ptr;
`endif
            w = pick(bus.req, start);
            if (m_holder >= 0 && bus.lock && bus.req[m_holder] && m_cnt < MAXH) begin
                m_cnt = m_cnt + 1;
            end else if (w >= 0) begin
                m_holder = w;
                m_cnt    = 1;
                m_ptr    = (w + 1) % N;
            end else begin
                m_holder = -1;
                m_cnt    = 0;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] eg;
            logic [31:0] eid;
            eg  = (m_holder < 0) ? 32'd0 : (32'd1 << m_holder);
            eid = (m_holder < 0) ? 32'd31 : 32'(m_holder);
            check("model.grant", bus.grant, eg);
            check("model.grant_id", 32'(bus.grant_id), eid);
            check("model.grant_en", 32'(bus.grant_en), 32'(m_holder >= 0));
            check("model.busy", 32'(bus.busy), 32'(m_holder >= 0));
        end
    end

    task automatic pulse_reset();
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n    = 1'b0;
        bus.req  = '0;
        bus.lock = 1'b0;
        repeat (2) @(negedge clk);
        check_out("reset", 32'h0, 32'd31);
        check("reset.busy", 32'(bus.busy), 32'd0);
        clr_n  = 1'b1;
        chk_en = 1'b1;

        // Single one-cycle request.
        bus.req = 24'h000020;
        @(negedge clk);
        bus.req = '0;
        check_out("single.t1", 32'h20, 32'd5);
        @(negedge clk);
        check_out("single.t2", 32'h0, 32'd31);

        // Asynchronous reset mid-grant; pointer must restart at 0 (5 wins over 7).
        bus.req = 24'h000020;
        @(negedge clk);
        check_out("prereset", 32'h20, 32'd5);
        #2 clr_n = 1'b0;
        #1;
        check_out("async_rst", 32'h0, 32'd31);
        check("async_rst.busy", 32'(bus.busy), 32'd0);
        bus.req = 24'h0000A0;
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check_out("post_rst", 32'h20, 32'd5);
        bus.req = '0;
        @(negedge clk);

`ifndef BUS_ARB_FIXED_PRIO_EN
        // Alternation between sources 0 and 4 with no idle cycles.
        pulse_reset();
        bus.req = 24'h000011;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i % 2 == 0) check_out("rr_alt", 32'h1, 32'd0);
            else            check_out("rr_alt", 32'h10, 32'd4);
        end
        bus.req = '0;
        @(negedge clk);

        // Lock limit: 3 held four cycles, then 7 four cycles, then back to 3.
        pulse_reset();
        bus.req  = 24'h000088;
        bus.lock = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i < 4 || i == 8) check_out("lock", 32'h8, 32'd3);
            else                 check_out("lock", 32'h80, 32'd7);
        end
        bus.req  = '0;
        bus.lock = 1'b0;
        @(negedge clk);

        // Wrap-around: grant 22 leaves ptr at 23; then 23 beats 0, then 0.
        bus.req = 24'h400000;
        @(negedge clk);
        check_out("wrap.22", 32'h00400000, 32'd22);
        bus.req = 24'h800001;
        @(negedge clk);
        check_out("wrap.23", 32'h00800000, 32'd23);
        @(negedge clk);
        check_out("wrap.0", 32'h1, 32'd0);
        bus.req = '0;
        @(negedge clk);
`else
        // Fixed priority: source 0 wins every cycle over source 4.
        pulse_reset();
        bus.req = 24'h000011;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_out("fixed", 32'h1, 32'd0);
        end
        bus.req = '0;
        @(negedge clk);
`endif

        // Random traffic; requests often kept so locks get exercised.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.req = '0;
                    1:       bus.req = 24'(32'd1 << $urandom_range(0, N - 1));
                    2:       bus.req = 24'($urandom & $urandom & $urandom);
                    default: bus.req = 24'($urandom);
                endcase
            end
            bus.lock = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                #3 clr_n = 1'b0;
                @(negedge clk);
                clr_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
